// File: rtl/gpu_cmd_issuer.sv
// gpu_cmd_issuer
// CPU-side initiator for the graphics unit command handshake.
// Commands from the datapath are queued in a small in-order FIFO. Each entry
// is presented to the GPU with the operand registers held stable, and inflag
// is raised as the request. Once outflag reports done, the command bus
// returns to NOP (3'b111) for at least one IDLE cycle before the next entry.
//
// Optional feature macro: GPU_ISSUE_TIMEOUT_EN. When it is defined, a WAIT
// watchdog abandons a request after TIMEOUT_CYCLES and sets timeout_err.
//
// Ports:
//   Clk, Reset_ah             clock, async active-high reset
//   enq, enq_command,         CPU push strobe plus the opcode, the
//   enq_indata, enq_r0..r2    immediate word and the R0/R1/R2 snapshots
//   full, busy                stall / drain status for the CPU
//   command, indata, R0..R2   registered request fields to the GPU
//   inflag                    2'b01 = request, 2'b00 = idle
//   outflag                   2'b01 one-cycle done pulse from the GPU
//   err_clr, timeout_err      watchdog error clear / sticky flag
module gpu_cmd_issuer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 8192
) (
    input  logic        Clk,
    input  logic        Reset_ah,
    input  logic        enq,
    input  logic [2:0]  enq_command,
    input  logic [15:0] enq_indata,
    input  logic [15:0] enq_r0,
    input  logic [15:0] enq_r1,
    input  logic [15:0] enq_r2,
    output logic        full,
    output logic        busy,
    output logic [2:0]  command,
    output logic [15:0] indata,
    output logic [15:0] R0,
    output logic [15:0] R1,
    output logic [15:0] R2,
    output logic [1:0]  inflag,
    input  logic [1:0]  outflag,
    input  logic        err_clr,
    output logic        timeout_err
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int EW = 3 + 4 * 16;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t        state_r, state_nxt_s;
    logic [EW-1:0] mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r, rd_ptr_r;
    logic [CW-1:0] count_r;

    logic [2:0]  command_r, command_nxt_s;
    logic [15:0] indata_r, indata_nxt_s;
    logic [15:0] r0_r, r0_nxt_s, r1_r, r1_nxt_s, r2_r, r2_nxt_s;
    logic [1:0]  inflag_r, inflag_nxt_s;

    logic        empty_s, full_s, pop_s, push_s, done_s, timeout_s;
    logic [2:0]  head_cmd_s;
    logic [15:0] head_indata_s, head_r0_s, head_r1_s, head_r2_s;

    assign empty_s = (count_r == {CW{1'b0}});
    assign full_s  = (count_r == CNT_FULL);
    // A pop frees a slot on the same edge, so a push while full is still taken.
    assign push_s  = enq && (!full_s || pop_s);
    assign done_s  = (state_r == ST_WAIT) && (outflag == 2'b01);
    assign {head_cmd_s, head_indata_s, head_r0_s, head_r1_s, head_r2_s} = mem_r[rd_ptr_r];

`ifdef GPU_ISSUE_TIMEOUT_EN
    localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wd_cnt_r;
    logic        timeout_err_r;

    // The limit compare fires in the TIMEOUT_CYCLES-th WAIT cycle.
    assign timeout_s   = (state_r == ST_WAIT) && (wd_cnt_r == WD_LIMIT);
    assign timeout_err = timeout_err_r;

    // Watchdog counter: cleared on entry to WAIT, counts WAIT cycles.
    always_ff @(posedge Clk or posedge Reset_ah) begin
        if (Reset_ah) begin
            wd_cnt_r <= 16'd0;
        end else if (pop_s) begin
            wd_cnt_r <= 16'd0;
        end else if (state_r == ST_WAIT) begin
            wd_cnt_r <= wd_cnt_r + 16'd1;
        end else begin
            wd_cnt_r <= wd_cnt_r;
        end
    end

    // Sticky error flag; a new timeout takes priority over a clear.
    always_ff @(posedge Clk or posedge Reset_ah) begin
        if (Reset_ah) begin
            timeout_err_r <= 1'b0;
        end else if (timeout_s) begin
            timeout_err_r <= 1'b1;
        end else if (err_clr) begin
            timeout_err_r <= 1'b0;
        end else begin
            timeout_err_r <= timeout_err_r;
        end
    end
`else
    logic unused_s;

    assign timeout_s   = 1'b0;
    assign timeout_err = 1'b0;
    assign unused_s    = ^{err_clr, 16'(TIMEOUT_CYCLES)};
`endif

    // FIFO storage: payload only, so no reset is needed.
    always_ff @(posedge Clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {enq_command, enq_indata, enq_r0, enq_r1, enq_r2};
        end
    end

    // FIFO pointers and occupancy; the pointers wrap naturally at FIFO_DEPTH.
    always_ff @(posedge Clk or posedge Reset_ah) begin
        if (Reset_ah) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // FSM and GPU-facing registers: every output to the GPU is a flop.
    always_ff @(posedge Clk or posedge Reset_ah) begin
        if (Reset_ah) begin
            state_r   <= ST_IDLE;
            command_r <= 3'b111;
            indata_r  <= 16'd0;
            r0_r      <= 16'd0;
            r1_r      <= 16'd0;
            r2_r      <= 16'd0;
            inflag_r  <= 2'b00;
        end else begin
            state_r   <= state_nxt_s;
            command_r <= command_nxt_s;
            indata_r  <= indata_nxt_s;
            r0_r      <= r0_nxt_s;
            r1_r      <= r1_nxt_s;
            r2_r      <= r2_nxt_s;
            inflag_r  <= inflag_nxt_s;
        end
    end

    // Next-state and next-output logic; everything holds unless changed below.
    always_comb begin
        state_nxt_s   = state_r;
        command_nxt_s = command_r;
        indata_nxt_s  = indata_r;
        r0_nxt_s      = r0_r;
        r1_nxt_s      = r1_r;
        r2_nxt_s      = r2_r;
        inflag_nxt_s  = inflag_r;
        pop_s         = 1'b0;
        case (state_r)
            ST_IDLE: begin
                command_nxt_s = 3'b111;
                inflag_nxt_s  = 2'b00;
                if (!empty_s) begin
                    pop_s         = 1'b1;
                    command_nxt_s = head_cmd_s;
                    indata_nxt_s  = head_indata_s;
                    r0_nxt_s      = head_r0_s;
                    r1_nxt_s      = head_r1_s;
                    r2_nxt_s      = head_r2_s;
                    inflag_nxt_s  = 2'b01;
                    state_nxt_s   = ST_WAIT;
                end else begin
                    state_nxt_s   = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // Drop the request on the same edge that samples done, so the
                // GPU never re-samples a stale request.
                if (done_s || timeout_s) begin
                    command_nxt_s = 3'b111;
                    inflag_nxt_s  = 2'b00;
                    state_nxt_s   = ST_IDLE;
                end else begin
                    state_nxt_s   = ST_WAIT;
                end
            end
            default: begin
                command_nxt_s = 3'b111;
                inflag_nxt_s  = 2'b00;
                state_nxt_s   = ST_IDLE;
            end
        endcase
    end

    assign command = command_r;
    assign indata  = indata_r;
    assign R0      = r0_r;
    assign R1      = r1_r;
    assign R2      = r2_r;
    assign inflag  = inflag_r;
    assign full    = full_s;
    assign busy    = !empty_s || (state_r == ST_WAIT);

endmodule

// File: tb/tb_gpu_cmd_issuer.sv
// Self-checking bench for gpu_cmd_issuer. A responder process plays the GPU.
// Each request it sees is checked against the scoreboard entry that was
// pushed when the command was enqueued.
module tb_gpu_cmd_issuer;

    typedef struct packed {
        logic [2:0]  cmd;
        logic [15:0] d;
        logic [15:0] r0;
        logic [15:0] r1;
        logic [15:0] r2;
    } req_t;

    logic        Clk = 1'b0;
    logic        Reset_ah = 1'b0;
    logic        enq = 1'b0;
    logic [2:0]  enq_command = 3'b000;
    logic [15:0] enq_indata = 16'd0, enq_r0 = 16'd0, enq_r1 = 16'd0, enq_r2 = 16'd0;
    logic        full, busy, timeout_err;
    logic [2:0]  command;
    logic [15:0] indata, R0, R1, R2;
    logic [1:0]  inflag;
    logic [1:0]  outflag = 2'b00;
    logic        err_clr = 1'b0;

    int   n_cmp = 0;
    int   n_fail = 0;
    req_t sb[$];
    bit   resp_en = 1'b1;
    bit   resp_active = 1'b0;
    bit   expect_abort = 1'b0;
    int   resp_cnt = 0;
    int   n_req = 0;

    gpu_cmd_issuer #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(8192)) dut (
        .Clk(Clk), .Reset_ah(Reset_ah), .enq(enq), .enq_command(enq_command),
        .enq_indata(enq_indata), .enq_r0(enq_r0), .enq_r1(enq_r1), .enq_r2(enq_r2),
        .full(full), .busy(busy), .command(command), .indata(indata),
        .R0(R0), .R1(R1), .R2(R2), .inflag(inflag), .outflag(outflag),
        .err_clr(err_clr), .timeout_err(timeout_err)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one enqueue for one cycle; returns at #1 after the sampling edge.
    task automatic push(input logic [2:0] c, input logic [15:0] d, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] e, input bit accept);
        req_t r;
        enq = 1'b1; enq_command = c; enq_indata = d; enq_r0 = a; enq_r1 = b; enq_r2 = e;
        r = {c, d, a, b, e};
        if (accept) sb.push_back(r);
        @(posedge Clk); #1;
        enq = 1'b0;
    endtask

    // GPU responder: sees a request, then pulses outflag three cycles later.
    initial begin
        req_t r;
        forever begin
            @(posedge Clk); #1;
            if (Reset_ah) begin
                resp_active = 1'b0;
                outflag = 2'b00;
            end else if (outflag == 2'b01) begin
                outflag = 2'b00;
                resp_active = 1'b0;
                check("done_inflag", inflag, 2'b00);
                check("done_command", command, 3'b111);
            end else if (resp_active) begin
                if (inflag != 2'b01) begin
                    check("request_abandoned_only_on_timeout", expect_abort, 1'b1);
                    resp_active = 1'b0;
                end else if (resp_en) begin
                    resp_cnt++;
                    if (resp_cnt == 3) outflag = 2'b01;
                end
            end else if (inflag == 2'b01) begin
                resp_active = 1'b1;
                resp_cnt = 0;
                n_req++;
                check("req_expected", sb.size() > 0, 1'b1);
                if (sb.size() > 0) begin
                    r = sb.pop_front();
                    check("req_command", command, r.cmd);
                    check("req_operands", {indata, R0, R1, R2}, {r.d, r.r0, r.r1, r.r2});
                end
            end
        end
    end

    initial begin
        int cyc, n0, starts, ends, s0, s1, viol;
        logic [2:0] prev;

        // Reset state
        Reset_ah = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        check("rst_command", command, 3'b111);
        check("rst_inflag", inflag, 2'b00);
        check("rst_full_busy", {full, busy}, 2'b00);
        check("rst_operands", {indata, R0, R1, R2}, 64'd0);
        check("rst_timeout_err", timeout_err, 1'b0);
        Reset_ah = 1'b0;
        @(posedge Clk); #1;
        check("post_rst_command", command, 3'b111);
        check("post_rst_inflag_busy", {inflag, busy}, 3'b000);

        // Single pixel op with 4-cycle request
        push(3'b000, 16'h0800, 16'd5, 16'd7, 16'd3, 1'b1);
        check("e0_inflag", inflag, 2'b00);
        check("e0_busy", busy, 1'b1);
        @(posedge Clk); #1;
        check("e1_inflag", inflag, 2'b01);
        check("e1_command", command, 3'b000);
        check("e1_operands", {indata, R0, R1, R2}, {16'h0800, 16'd5, 16'd7, 16'd3});
        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge Clk); #1;
            cyc++;
            if (inflag == 2'b00) break;
        end
        check("single_inflag_drop", inflag, 2'b00);
        check("single_req_len", cyc, 4);
        check("single_cmd_nop", command, 3'b111);
        @(posedge Clk); #1;
        check("single_busy_clear", busy, 1'b0);

        // FIFO full with a stalled responder
        resp_en = 1'b0;
        push(3'b011, 16'h1111, 16'd1, 16'd1, 16'd1, 1'b1);
        @(posedge Clk); #1;
        check("blocker_inflag", inflag, 2'b01);
        push(3'b000, 16'h0100, 16'd10, 16'd11, 16'd12, 1'b1);
        push(3'b001, 16'h0200, 16'd20, 16'd21, 16'd22, 1'b1);
        push(3'b010, 16'h0300, 16'd30, 16'd31, 16'd32, 1'b1);
        check("full_after_3", full, 1'b0);
        push(3'b100, 16'h0400, 16'd40, 16'd41, 16'd42, 1'b1);
        check("full_after_4", full, 1'b1);
        push(3'b101, 16'h0500, 16'd50, 16'd51, 16'd52, 1'b0);
        check("full_after_drop", {full, busy}, 2'b11);
        n0 = n_req;
        resp_en = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge Clk); #1;
            if (!busy) break;
        end
        check("drain_busy", busy, 1'b0);
        check("drain_req_count", n_req - n0, 4);
        check("drain_sb_empty", sb.size(), 0);

        // Back-to-back swap commands
        n0 = n_req;
        push(3'b110, 16'h0001, 16'd0, 16'd0, 16'd0, 1'b1);
        push(3'b110, 16'h0002, 16'd0, 16'd0, 16'd0, 1'b1);
        starts = 0; ends = 0; s0 = 0; s1 = 0; prev = 3'b111;
        for (int i = 0; i < 40; i++) begin
            if (command == 3'b110 && prev != 3'b110) begin
                if (starts == 0) s0 = i; else s1 = i;
                starts++;
            end
            if (prev == 3'b110 && command == 3'b111) ends++;
            prev = command;
            @(posedge Clk); #1;
        end
        check("swap_starts", starts, 2);
        check("swap_nop_gaps", ends, 2);
        check("swap_issue_spacing", s1 - s0, 5);
        check("swap_req_count", n_req - n0, 2);

`ifdef GPU_ISSUE_TIMEOUT_EN
        // Watchdog with a silent responder
        resp_en = 1'b0;
        expect_abort = 1'b1;
        push(3'b001, 16'hAAAA, 16'd1, 16'd2, 16'd3, 1'b1);
        push(3'b010, 16'hBBBB, 16'd4, 16'd5, 16'd6, 1'b1);
        check("to_inflag_up", inflag, 2'b01);
        cyc = 0;
        for (int i = 0; i < 9000; i++) begin
            @(posedge Clk); #1;
            cyc++;
            if (inflag == 2'b00) break;
        end
        check("to_inflag_drop", inflag, 2'b00);
        check("to_wait_cycles", cyc, 8192);
        check("to_err_set", timeout_err, 1'b1);
        check("to_cmd_nop", command, 3'b111);
        expect_abort = 1'b0;
        resp_en = 1'b1;
        @(posedge Clk); #1;
        check("to_next_issue", {inflag, command}, {2'b01, 3'b010});
        for (int i = 0; i < 50; i++) begin
            @(posedge Clk); #1;
            if (!busy) break;
        end
        check("to_next_done", busy, 1'b0);
        check("to_err_sticky", timeout_err, 1'b1);
        err_clr = 1'b1;
        @(posedge Clk); #1;
        err_clr = 1'b0;
        check("to_err_clr", timeout_err, 1'b0);
`else
        // No watchdog: the request waits indefinitely
        resp_en = 1'b0;
        push(3'b001, 16'hAAAA, 16'd1, 16'd2, 16'd3, 1'b1);
        @(posedge Clk); #1;
        viol = 0;
        for (int i = 0; i < 20000; i++) begin
            @(posedge Clk); #1;
            if (inflag !== 2'b01) viol++;
            if (timeout_err !== 1'b0) viol++;
        end
        check("nowd_hold_violations", viol, 0);
        check("nowd_inflag", inflag, 2'b01);
        check("nowd_err", timeout_err, 1'b0);
`endif

        // Asynchronous reset in the middle of WAIT
        resp_en = 1'b0;
        push(3'b100, 16'h4444, 16'd9, 16'd9, 16'd9, 1'b1);
        push(3'b101, 16'h5555, 16'd8, 16'd8, 16'd8, 1'b1);
        @(posedge Clk); #1;
        check("mid_wait_inflag", inflag, 2'b01);
        #2;
        Reset_ah = 1'b1;
        #1;
        check("async_rst_command", command, 3'b111);
        check("async_rst_inflag", inflag, 2'b00);
        check("async_rst_full_busy", {full, busy}, 2'b00);
        check("async_rst_operands", {indata, R0, R1, R2}, 64'd0);
        check("async_rst_err", timeout_err, 1'b0);
        sb.delete();
        @(posedge Clk); #1;
        Reset_ah = 1'b0;
        resp_en = 1'b1;
        @(posedge Clk); #1;
        check("after_rst_idle", {busy, inflag}, 3'b000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
